minhash_bottomk_sorter: RTL

//   Streaming bottom-K MinHash sketch builder with valid/ready handshake. Keeps the K smallest

---
 rtl/minhash_bottomk_sorter_if.sv | 30 +++
 rtl/minhash_bottomk_sorter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/minhash_bottomk_sorter_if.sv
// Stream bundle for the bottom-K MinHash sorter: signature input stream,
// sorted output stream and sketch status.
interface minhash_bottomk_sorter_if #(
    parameter int SIGNATURE_WIDTH = 32,
    parameter int INDEX_WIDTH     = 10,
    parameter int LOG_COMPARATORS = 3
);
    logic                       in_valid;
    logic                       in_ready;
    logic [SIGNATURE_WIDTH-1:0] signature_in;
    logic [INDEX_WIDTH-1:0]     index_in;
    logic                       in_last;
    logic                       out_valid;
    logic                       out_ready;
    logic [SIGNATURE_WIDTH-1:0] out_signature;
    logic [INDEX_WIDTH-1:0]     out_index;
    logic                       out_last;
    logic                       done;
    logic [LOG_COMPARATORS:0]   count;

    modport master (
        output in_valid, signature_in, index_in, in_last, out_ready,
        input  in_ready, out_valid, out_signature, out_index, out_last, done, count
    );

    modport slave (
        input  in_valid, signature_in, index_in, in_last, out_ready,
        output in_ready, out_valid, out_signature, out_index, out_last, done, count
    );
endinterface

// File: rtl/minhash_bottomk_sorter.sv
// Streaming bottom-K MinHash sketch: retains the K smallest distinct signatures
// of a sequence, then drains them in ascending order and clears.
//
// state   | meaning
// COLLECT | accepting signatures, updating the bottom-K slots
// DRAIN   | emitting smallest unsent slot each handshake
// CLEAR   | one-cycle wipe of slots, done pulse
module minhash_bottomk_sorter #(
    parameter int SIGNATURE_WIDTH = 32,
    parameter int INDEX_WIDTH     = 10,
    parameter int NUM_COMPARATORS = 8,
    parameter int LOG_COMPARATORS = 3
) (
    input logic                    clk,
    input logic                    rst_n,
    minhash_bottomk_sorter_if.slave bus
);
    localparam int K = NUM_COMPARATORS;
    localparam logic [LOG_COMPARATORS:0] K_CNT = (LOG_COMPARATORS+1)'(NUM_COMPARATORS);

    typedef enum logic [1:0] {COLLECT, DRAIN, CLEAR} state_t;

    state_t                     state;
    logic [SIGNATURE_WIDTH-1:0] sig_q [K];
    logic [INDEX_WIDTH-1:0]     idx_q [K];
    logic [K-1:0]               vld_q;
    logic [K-1:0]               sent_q;
    logic [LOG_COMPARATORS:0]   count_q;
    logic                       in_ready_q;
    logic                       out_valid_q;
    logic                       done_q;

    logic                       dup_hit;
    logic [LOG_COMPARATORS-1:0] free_pos;
    logic [LOG_COMPARATORS-1:0] max_pos;
    logic [LOG_COMPARATORS-1:0] min_pos;
    logic                       min_found;
    logic [LOG_COMPARATORS:0]   unsent;
    logic                       accept;
    logic                       store_new;
    logic                       cur_last;

    // All selections look only at the registered slot array, so a write is
    // visible to the next accepted signature one cycle later.
    always_comb begin
        dup_hit   = 1'b0;
        free_pos  = '0;
        max_pos   = '0;
        min_pos   = '0;
        min_found = 1'b0;
        unsent    = '0;
        for (int i = K-1; i >= 0; i--) begin
            if (!vld_q[i]) free_pos = LOG_COMPARATORS'(i);
        end
        for (int i = 0; i < K; i++) begin
            if (vld_q[i] && sig_q[i] == bus.signature_in) dup_hit = 1'b1;
            if (vld_q[i] && sig_q[i] > sig_q[max_pos]) max_pos = LOG_COMPARATORS'(i);
            if (vld_q[i] && !sent_q[i]) begin
                unsent = unsent + 1'b1;
                if (!min_found || sig_q[i] < sig_q[min_pos]) begin
                    min_pos   = LOG_COMPARATORS'(i);
                    min_found = 1'b1;
                end
            end
        end
    end

    assign accept    = bus.in_valid && in_ready_q;
    assign store_new = accept && !dup_hit && (count_q < K_CNT);
    assign cur_last  = out_valid_q && (unsent == (LOG_COMPARATORS+1)'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= COLLECT;
            vld_q       <= '0;
            sent_q      <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < K; i++) begin
                sig_q[i] <= '0;
                idx_q[i] <= '0;
            end
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        if (store_new) begin
                            sig_q[free_pos] <= bus.signature_in;
                            idx_q[free_pos] <= bus.index_in;
                            vld_q[free_pos] <= 1'b1;
                            count_q         <= count_q + 1'b1;
                        end else if (!dup_hit && bus.signature_in < sig_q[max_pos]) begin
                            sig_q[max_pos] <= bus.signature_in;
                            idx_q[max_pos] <= bus.index_in;
                        end
                        if (bus.in_last) begin
                            in_ready_q <= 1'b0;
                            if (count_q == '0 && !store_new) begin
                                state  <= CLEAR;
                                done_q <= 1'b1;
                            end else begin
                                state       <= DRAIN;
                                out_valid_q <= 1'b1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (bus.out_ready) begin
                        sent_q[min_pos] <= 1'b1;
                        if (cur_last) begin
                            state       <= CLEAR;
                            out_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                        end
                    end
                end
                default: begin
                    vld_q      <= '0;
                    sent_q     <= '0;
                    count_q    <= '0;
                    done_q     <= 1'b0;
                    in_ready_q <= 1'b1;
                    state      <= COLLECT;
                end
            endcase
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_signature = out_valid_q ? sig_q[min_pos] : '0;
    assign bus.out_index     = out_valid_q ? idx_q[min_pos] : '0;
    assign bus.out_last      = cur_last;
    assign bus.done          = done_q;
    assign bus.count         = count_q;
endmodule
